// File: rtl/matrix_row_dot.sv
// matrix_row_dot: streams the rows of a matrix and computes the signed dot
// product of each row with a fixed column vector. There is one result per row
// and no gaps between results.
//
// The pipeline has three registered stages:
//   capture -> N signed products -> sum, reduction and result register.
// The result for a row is available 2 cycles after that row is captured.
//
// Ports:
//   clk, rst      : single clock; synchronous, active-high reset
//   start         : pulse that begins a matrix (honored only when idle)
//   row_in        : current row, element j at bits [j*W : j*W+W-1]
//   vec_in        : column vector, same packing, held stable while busy
//   result        : dot product of one row with vec_in (OUT_W bits)
//   result_idx    : row index of result, counting from 0
//   result_valid  : result and result_idx are valid this cycle
//   busy          : a matrix is in progress
//   done          : pulses together with the last result
//
// Optional feature: define MATRIX_ROW_DOT_SAT_EN to clamp the full-precision
// sum to the OUT_W signed range. Without it, the sum wraps to the low OUT_W bits.

module matrix_row_dot #(
   parameter int unsigned N     = 128,
   parameter int unsigned W     = 16,
   parameter int unsigned ROWS  = 128,
   parameter int unsigned OUT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [0:N*W-1]     row_in,
   input  logic [0:N*W-1]     vec_in,
   output logic [OUT_W-1:0]   result,
   output logic [7:0]         result_idx,
   output logic               result_valid,
   output logic               busy,
   output logic               done
);

   localparam int unsigned PROD_W = 2 * W;
   localparam int unsigned SUM_W  = PROD_W + $clog2(N);
   // One guard bit above the wider of the sum and the result, for the clamp
   localparam int unsigned EXT_W  = ((SUM_W > OUT_W) ? SUM_W : OUT_W) + 1;
   localparam int unsigned IDX_W  = 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t                    state_q, state_d;
   logic [IDX_W-1:0]          cnt_q, cnt_d;
   logic                      busy_q, busy_d;

   logic                      cap_valid_q, cap_valid_d;
   logic [IDX_W-1:0]          cap_idx_q, cap_idx_d;
   logic [0:N*W-1]            cap_row_q, cap_row_d;
   logic [0:N*W-1]            cap_vec_q, cap_vec_d;

   logic                      prod_valid_q, prod_valid_d;
   logic [IDX_W-1:0]          prod_idx_q, prod_idx_d;
   logic signed [PROD_W-1:0]  prod_q [N];
   logic signed [PROD_W-1:0]  prod_d [N];

   logic [OUT_W-1:0]          result_q, result_d;
   logic [IDX_W-1:0]          result_idx_q, result_idx_d;
   logic                      result_valid_q, result_valid_d;
   logic                      done_q, done_d;

   logic signed [W-1:0]       a_c, b_c;
   logic signed [SUM_W-1:0]   sum_c;
   logic signed [EXT_W-1:0]   sum_ext_c;
   logic [OUT_W-1:0]          red_c;

   // Control: state, row counter and capture stage
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cap_valid_d = 1'b0;
      cap_idx_d   = cap_idx_q;
      cap_row_d   = cap_row_q;
      cap_vec_d   = cap_vec_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            cap_valid_d = 1'b1;
            cap_idx_d   = cnt_q;
            cap_row_d   = row_in;
            cap_vec_d   = vec_in;
            cnt_d       = cnt_q + IDX_W'(1);
            if (cnt_q == LAST_IDX) state_d = DRAIN;
         end
         DRAIN: begin
            // done_q marks the cycle carrying the last result
            if (done_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // Stage 1: element-wise signed products
   always_comb begin
      a_c          = '0;
      b_c          = '0;
      prod_valid_d = cap_valid_q;
      prod_idx_d   = cap_idx_q;
      for (int unsigned j = 0; j < N; j++) begin
         a_c       = $signed(cap_row_q[j*W +: W]);
         b_c       = $signed(cap_vec_q[j*W +: W]);
         prod_d[j] = PROD_W'(a_c) * PROD_W'(b_c);
      end
   end

   // Stage 2: full-precision sum of the products, then reduction to OUT_W
   always_comb begin
      sum_c = '0;
      for (int unsigned j = 0; j < N; j++) begin
         sum_c = sum_c + SUM_W'(prod_q[j]);
      end
      sum_ext_c = EXT_W'(sum_c);
   end

`ifdef MATRIX_ROW_DOT_SAT_EN
   localparam logic signed [EXT_W-1:0] SAT_MAX =
      {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN =
      {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   always_comb begin
      if (sum_ext_c > SAT_MAX)      red_c = OUT_W'(SAT_MAX);
      else if (sum_ext_c < SAT_MIN) red_c = OUT_W'(SAT_MIN);
      else                          red_c = OUT_W'(sum_ext_c);
   end
`else
   logic unused_sum_bits;

   always_comb begin
      red_c = OUT_W'(sum_ext_c);
   end

   // Bits above OUT_W are dropped by design in wrap mode
   assign unused_sum_bits = ^sum_ext_c;
`endif

   // Output stage: result holds its last value between valid cycles
   always_comb begin
      result_valid_d = prod_valid_q;
      result_d       = result_q;
      result_idx_d   = result_idx_q;
      done_d         = prod_valid_q && (prod_idx_q == LAST_IDX);
      if (prod_valid_q) begin
         result_d     = red_c;
         result_idx_d = prod_idx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         busy_q         <= 1'b0;
         cap_valid_q    <= 1'b0;
         cap_idx_q      <= '0;
         cap_row_q      <= '0;
         cap_vec_q      <= '0;
         prod_valid_q   <= 1'b0;
         prod_idx_q     <= '0;
         for (int unsigned j = 0; j < N; j++) prod_q[j] <= '0;
         result_q       <= '0;
         result_idx_q   <= '0;
         result_valid_q <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         busy_q         <= busy_d;
         cap_valid_q    <= cap_valid_d;
         cap_idx_q      <= cap_idx_d;
         cap_row_q      <= cap_row_d;
         cap_vec_q      <= cap_vec_d;
         prod_valid_q   <= prod_valid_d;
         prod_idx_q     <= prod_idx_d;
         prod_q         <= prod_d;
         result_q       <= result_d;
         result_idx_q   <= result_idx_d;
         result_valid_q <= result_valid_d;
         done_q         <= done_d;
      end
   end

   assign result       = result_q;
   assign result_idx   = result_idx_q;
   assign result_valid = result_valid_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule

// File: tb/tb_matrix_row_dot.sv
// Bench for matrix_row_dot: table-driven matrices with a scoreboard checked at
// the falling edge, plus sequences for reset, ignored starts, back-to-back
// matrices and the 8-bit reduction corner.

module tb_matrix_row_dot;

   localparam int unsigned N = 4, W = 8, ROWS = 4, OUT_W = 16;

`ifdef MATRIX_ROW_DOT_SAT_EN
   localparam logic [15:0] T2_R0 = 16'h7FFF;
   localparam logic [15:0] T2_R1 = 16'h8000;
   localparam logic [7:0]  EXP27 = 8'h7F;
`else
   localparam logic [15:0] T2_R0 = 16'h0000;
   localparam logic [15:0] T2_R1 = 16'h0200;
   localparam logic [7:0]  EXP27 = 8'h04;
`endif

   typedef struct {
      int          vec[4];
      int          rows[4][4];
      logic [15:0] exp[4];
   } vec_t;

   typedef struct {
      logic [15:0] res;
      logic [7:0]  idx;
      logic        done;
      int          cyc;
   } sb_t;

   logic              clk = 1'b0;
   logic              rst, start, start2;
   logic [0:N*W-1]    row_in, vec_in, row2;
   logic [OUT_W-1:0]  result;
   logic [7:0]        result_idx, result_idx2;
   logic              result_valid, busy, done;
   logic [7:0]        result2;
   logic              result_valid2, busy2, done2;

   vec_t tbl[3];
   sb_t  sbq[$];
   int   checks = 0, passes = 0, done_cnt = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   matrix_row_dot #(.N(N), .W(W), .ROWS(ROWS), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .row_in(row_in), .vec_in(vec_in),
      .result(result), .result_idx(result_idx), .result_valid(result_valid),
      .busy(busy), .done(done));

   matrix_row_dot #(.N(N), .W(W), .ROWS(ROWS), .OUT_W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start2), .row_in(row2), .vec_in(row2),
      .result(result2), .result_idx(result_idx2), .result_valid(result_valid2),
      .busy(busy2), .done(done2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_now(input string name);
      checks++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic logic [0:N*W-1] pack(input int e[4]);
      logic [0:N*W-1] p;
      for (int j = 0; j < 4; j++) p[j*W +: W] = 8'(e[j]);
      return p;
   endfunction

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      sb_t e;
      if (result_valid === 1'b1) begin
         if (sbq.size() == 0) fail_now("unexpected_result_valid");
         else begin
            e = sbq.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("result_idx", 32'(result_idx), 32'(e.idx));
            chk("done_flag", 32'(done), 32'(e.done));
            chk("result_cycle", cyc, e.cyc);
         end
      end else if (done === 1'b1) fail_now("done_without_valid");
      if (done === 1'b1) done_cnt++;
   end

   // mode 0: plain; 1: extra start at E2; 2: start during the done cycle
   task automatic run_matrix(input int t, input int mode);
      int d0;
      bit seen;
      d0 = done_cnt;
      seen = 1'b0;
      chk("busy_before_start", 32'(busy), 0);
      start  = 1'b1;
      vec_in = pack(tbl[t].vec);
      row_in = '0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_e0", 32'(busy), 1);
      for (int k = 0; k < 4; k++) begin
         row_in = pack(tbl[t].rows[k]);
         sbq.push_back('{tbl[t].exp[k], 8'(k), 1'(k == 3), cyc + 3});
         start = (mode == 1 && k == 1);
         @(posedge clk); #1;
      end
      start  = 1'b0;
      row_in = $urandom();
      for (int i = 0; i < 12 && !seen; i++) begin
         if (done === 1'b1) seen = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      if (!seen) fail_now("done_timeout");
      else chk("busy_with_done", 32'(busy), 1);
      if (mode == 2) start = 1'b1;
      @(negedge clk); #1;
      chk("scoreboard_drained", sbq.size(), 0);
      chk("done_count", done_cnt - d0, 1);
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_done", 32'(busy), 0);
   endtask

   initial begin
      int d0, n, nd;
      tbl[0].vec  = '{1, 2, 3, 4};
      tbl[0].rows = '{'{1, 0, 0, 0}, '{0, 1, 0, 0}, '{1, 1, 1, 1}, '{2, 2, 2, 2}};
      tbl[0].exp  = '{16'd1, 16'd2, 16'd10, 16'd20};
      tbl[1].vec  = '{1, 2, 3, 4};
      tbl[1].rows = '{'{-1, -1, -1, -1}, '{127, 127, 127, 127}, '{-128, 0, 0, 0}, '{0, 0, 0, 5}};
      tbl[1].exp  = '{16'hFFF6, 16'h04F6, 16'hFF80, 16'h0014};
      tbl[2].vec  = '{-128, -128, -128, -128};
      tbl[2].rows = '{'{-128, -128, -128, -128}, '{127, 127, 127, 127}, '{1, -1, 1, -1}, '{-1, -1, -1, -1}};
      tbl[2].exp  = '{T2_R0, T2_R1, 16'h0000, 16'h0200};

      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      row_in = '0; vec_in = '0;
      row2 = {8'd127, 8'd127, 8'd127, 8'd127};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_result", 32'(result), 0);
      chk("rst_result_idx", 32'(result_idx), 0);
      chk("rst_result_valid", 32'(result_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_valid_out8", 32'(result_valid2), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Table matrices, back to back with start in the cycle after done
      for (int t = 0; t < 3; t++) run_matrix(t, 0);
      // Restart attempt while busy
      run_matrix(0, 1);
      // Start coinciding with done, then idle must persist
      run_matrix(1, 2);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("idle_after_done_start", 32'(busy), 0);
      end

      // Reset in the cycle after E2 abandons the matrix
      d0 = done_cnt;
      start = 1'b1; vec_in = pack(tbl[0].vec);
      @(posedge clk); #1;
      start = 1'b0; row_in = pack(tbl[0].rows[0]);
      @(posedge clk); #1;
      row_in = pack(tbl[0].rows[1]);
      @(posedge clk); #1;
      rst = 1'b1; row_in = pack(tbl[0].rows[2]);
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_result", 32'(result), 0);
      chk("midrst_idx", 32'(result_idx), 0);
      chk("midrst_valid", 32'(result_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      repeat (10) @(posedge clk);
      #1;
      chk("midrst_no_done", done_cnt - d0, 0);
      chk("midrst_busy_later", 32'(busy), 0);

      // 8-bit result: 64516 wraps to 0x04, saturates to 0x7F
      start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      chk("out8_busy", 32'(busy2), 1);
      n = 0; nd = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (result_valid2 === 1'b1) begin
            chk("out8_result", 32'(result2), 32'(EXP27));
            chk("out8_idx", 32'(result_idx2), n);
            n++;
         end
         if (done2 === 1'b1) begin
            nd++;
            chk("out8_done_idx", 32'(result_idx2), 3);
         end
      end
      chk("out8_result_count", n, 4);
      chk("out8_done_count", nd, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
